// File: rtl/sqrt_arbiter.sv
// Round-robin front end that time-shares one iterative fixed-point square root
// unit between NUM_REQ requesters, tagging each result with its owner's id.

module fp_sqrt #(
   parameter int WIDTH      = 32,
   parameter int INT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 16
) (
   input  logic             clk,
   input  logic             go,
   input  logic [WIDTH-1:0] op,
   output logic [WIDTH-1:0] out,
   output logic             done
);
   localparam int RW = INT_WIDTH + 2 * FRAC_WIDTH;
   localparam int QW = RW >> 1;
   localparam int CW = $clog2(QW + 1);

   logic [RW-1:0]   rad_q;
   logic [RW-1:0]   rad_ld;
   logic [QW-1:0]   rem_q;
   logic [QW-1:0]   root_q;
   logic [CW-1:0]   cnt_q;
   logic            done_q;
   logic [2*QW-1:0] st_ld;
   logic [2*QW-1:0] st_it;

   // One restoring digit step: two radicand bits in, one root bit out.
   function automatic logic [2*QW-1:0] step(
      input logic [QW-1:0] rem,
      input logic [QW-1:0] root,
      input logic [1:0]    b
   );
      logic [QW+1:0] r;
      logic [QW+1:0] t;
      r = {rem, b};
      t = {root, 2'b01};
      if (r >= t) step = {QW'(r - t), root[QW-2:0], 1'b1};
      else        step = {QW'(r), root[QW-2:0], 1'b0};
   endfunction

   assign rad_ld = {op, {FRAC_WIDTH{1'b0}}};
   assign st_ld  = step('0, '0, rad_ld[RW-1 -: 2]);
   assign st_it  = step(rem_q, root_q, rad_q[RW-1 -: 2]);

   // The first digit is resolved on the go edge so done lands QW cycles later.
   always_ff @(posedge clk) begin
      if (go) begin
         rad_q           <= rad_ld << 2;
         {rem_q, root_q} <= st_ld;
         cnt_q           <= CW'(QW - 1);
         done_q          <= (QW == 1);
      end else begin
         done_q <= (cnt_q == CW'(1));
         if (cnt_q != '0) begin
            rad_q           <= rad_q << 2;
            {rem_q, root_q} <= st_it;
            cnt_q           <= cnt_q - 1'b1;
         end
      end
   end

   assign out  = WIDTH'(root_q);
   assign done = done_q;
endmodule

module sqrt_arbiter #(
   parameter int WIDTH      = 32,
   parameter int INT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int ITER       = (WIDTH + FRAC_WIDTH) >> 1,
   parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH-1:0]         resp_data,
   output logic [IDW-1:0]           resp_id,
   output logic                     resp_err,
   output logic                     busy
);
   localparam int FW = $clog2(ITER + 3);
   localparam int WDW = $clog2(ITER + 5);
   localparam logic [IDW:0] NQ = (IDW + 1)'(NUM_REQ);

   typedef enum logic [2:0] {
      FLUSH,
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t           state_q;
   logic [FW-1:0]    flush_q;
   logic [WDW-1:0]   wd_q;
   logic [IDW-1:0]   last_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] op_q;
   logic [WIDTH-1:0] resp_data_q;
   logic             resp_err_q;
   logic             resp_valid_q;
   logic             busy_q;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW:0]     cand;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [WIDTH-1:0] op_sel;
   logic             unit_go;
   logic [WIDTH-1:0] unit_out;
   logic             unit_done;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_q} + (IDW + 1)'(k);
         if (cand >= NQ) cand = cand - NQ;
         if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      op_sel = '0;
      gnt_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == gnt_idx) begin
            op_sel    = req_data[i*WIDTH +: WIDTH];
            gnt_oh[i] = gnt_found;
         end
      end
   end

   assign req_ready = (state_q == IDLE) ? gnt_oh : '0;
   assign unit_go   = (state_q == ISSUE);

   fp_sqrt #(
      .WIDTH     (WIDTH),
      .INT_WIDTH (INT_WIDTH),
      .FRAC_WIDTH(FRAC_WIDTH)
   ) u_sqrt (
      .clk (clk),
      .go  (unit_go),
      .op  (op_q),
      .out (unit_out),
      .done(unit_done)
   );

   // FLUSH lets any operation left over from before reset drain out unseen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FLUSH;
         flush_q      <= FW'(ITER + 2);
         wd_q         <= '0;
         last_q       <= IDW'(NUM_REQ - 1);
         id_q         <= '0;
         op_q         <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         unique case (state_q)
            FLUSH: begin
               flush_q <= flush_q - 1'b1;
               if (flush_q == FW'(1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            IDLE: begin
               if (gnt_found) begin
                  op_q    <= op_sel;
                  id_q    <= gnt_idx;
                  last_q  <= gnt_idx;
                  state_q <= ISSUE;
                  busy_q  <= 1'b1;
               end
            end
            ISSUE: begin
               wd_q    <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (unit_done) begin
                  resp_data_q  <= unit_out;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else if (wd_q == WDW'(ITER + 3)) begin
                  resp_data_q  <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q <= FLUSH;
               flush_q <= FW'(ITER + 2);
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_id    = id_q;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: directed scenarios plus random traffic
// scored against a round-robin / integer-sqrt reference model.

module tb_sqrt_arbiter;
   localparam int W  = 32;
   localparam int F  = 16;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int IT = (W + F) >> 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           resp_valid;
   logic           resp_ready = 1'b1;
   logic [W-1:0]   resp_data;
   logic [IW-1:0]  resp_id;
   logic           resp_err;
   logic           busy;
   logic [W-1:0]   dat [N];

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
   end

   sqrt_arbiter #(
      .WIDTH(W), .INT_WIDTH(16), .FRAC_WIDTH(F), .NUM_REQ(N)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
      .busy(busy)
   );

   typedef struct {
      int     id;
      longint dat;
      bit     err;
      int     lat;
      int     c;
   } exp_t;

   exp_t   q[$];
   exp_t   cur;
   int     nchecks = 0;
   int     nfail = 0;
   int     cyc = 0;
   int     last_m = N - 1;
   int     last_gcyc = -1;
   int     ngrant = 0;
   bit     held = 0;
   bit     auto_drop = 1;
   bit     rand_mode = 0;
   bit     chk_space = 0;
   bit     wd_mode = 0;
   logic [N-1:0] gmask = '0;
   int     gq[$];
   longint rq[$];
   longint last_rdata = 0;
   bit     last_rerr = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      nchecks++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // floor(sqrt(x * 2^F)) by binary search
   function automatic longint isqrt_fx(input longint x);
      longint v, lo, hi, mid;
      v  = x << F;
      lo = 0;
      hi = longint'(1) << IT;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   task automatic model_reset();
      q.delete();
      gq.delete();
      rq.delete();
      last_m    = N - 1;
      last_gcyc = -1;
      held      = 0;
      gmask     = '0;
      ngrant    = 0;
   endtask

   task automatic mon();
      int   eg;
      exp_t e;
      if (reset) begin
         gmask = '0;
         held  = 0;
         return;
      end
      if (req_ready != '0) begin
         chk("onehot", $countones(req_ready), 1);
         eg = rr_pick(req_valid, last_m);
         chk("grant", req_ready, (eg >= 0) ? (longint'(1) << eg) : 0);
         if (chk_space && last_gcyc >= 0) chk("spacing", cyc - last_gcyc, IT + 3);
         if (eg >= 0) begin
            e.id  = eg;
            e.dat = wd_mode ? 0 : isqrt_fx(longint'(dat[eg]));
            e.err = wd_mode;
            e.lat = wd_mode ? IT + 6 : IT + 2;
            e.c   = cyc;
            q.push_back(e);
            last_m = eg;
            gq.push_back(eg);
         end
         last_gcyc = cyc;
         ngrant++;
      end
      gmask = req_ready;
      if (resp_valid) begin
         if (!held) begin
            if (q.size() == 0) begin
               chk("stray_resp", 1, 0);
               cur = '{id: resp_id, dat: resp_data, err: resp_err, lat: 0, c: cyc};
            end else begin
               cur = q.pop_front();
               chk("latency", cyc - cur.c, cur.lat);
            end
            rq.push_back(longint'(resp_data));
         end
         chk("rdata", resp_data, cur.dat);
         chk("rid", resp_id, cur.id);
         chk("rerr", resp_err, cur.err);
         last_rdata = resp_data;
         last_rerr  = resp_err;
         held = !resp_ready;
      end else begin
         held = 0;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
      if (auto_drop) req_valid = req_valid & ~gmask;
      gmask = '0;
      if (rand_mode) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(3) == 0) begin
               req_valid[i] = 1'b1;
               dat[i] = $urandom;
            end
         end
         resp_ready = ($urandom_range(2) != 0);
      end
   endtask

   task automatic smp();
      @(negedge clk);
      mon();
   endtask

   task automatic cycle();
      adv();
      smp();
   endtask

   task automatic flush_count(output int n);
      n = 0;
      while (req_ready == '0 && n < 100) begin
         cycle();
         n++;
      end
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((q.size() != 0 || resp_valid || req_valid != '0) && k < maxc) begin
         cycle();
         k++;
      end
      chk("drain_pending", q.size() + int'(resp_valid), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"}, req_ready, 0);
      chk({tag, "_rv"}, resp_valid, 0);
      chk({tag, "_rd"}, resp_data, 0);
      chk({tag, "_rid"}, resp_id, 0);
      chk({tag, "_rerr"}, resp_err, 0);
      chk({tag, "_busy"}, busy, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0d exp=<100000 cycles", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      int k;
      for (int i = 0; i < N; i++) dat[i] = '0;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst");

      // single request from 1 with 4.0, flush length, latency
      adv();
      reset = 1'b0;
      req_valid = 4'b0010;
      dat[1] = 32'h0004_0000;
      flush_count(n);
      chk("flush_len", n, IT + 2);
      drain(200);
      chk("sqrt4", last_rdata, 32'h0002_0000);
      chk("busy_idle", busy, 0);

      // four continuous requesters after a fresh reset
      adv();
      reset = 1'b1;
      model_reset();
      adv();
      reset = 1'b0;
      auto_drop = 0;
      chk_space = 1;
      req_valid = 4'b1111;
      dat[0] = 32'h0001_0000;
      dat[1] = 32'h0004_0000;
      dat[2] = 32'h0009_0000;
      dat[3] = 32'h0002_0000;
      flush_count(n);
      chk("flush_len2", n, IT + 2);
      k = 0;
      while (ngrant < 8 && k < 400) begin
         cycle();
         k++;
      end
      chk("c_ngrant", ngrant, 8);
      adv();
      req_valid = '0;
      chk_space = 0;
      auto_drop = 1;
      smp();
      drain(100);
      for (int i = 0; i < 8; i++) chk("c_order", (gq.size() > i) ? gq[i] : -1, i % 4);
      chk("c_res0", (rq.size() > 0) ? rq[0] : -1, 32'h0001_0000);
      chk("c_res1", (rq.size() > 1) ? rq[1] : -1, 32'h0002_0000);
      chk("c_res2", (rq.size() > 2) ? rq[2] : -1, 32'h0003_0000);
      chk("c_res3", (rq.size() > 3) ? rq[3] : -1, 32'h0001_6A09);

      // round-robin wrap after a grant to 3
      gq.delete();
      adv();
      req_valid = 4'b0101;
      dat[0] = $urandom;
      dat[2] = $urandom;
      smp();
      drain(200);
      chk("wrap_first", (gq.size() > 0) ? gq[0] : -1, 0);
      chk("wrap_second", (gq.size() > 1) ? gq[1] : -1, 2);

      // backpressure in RESP
      adv();
      resp_ready = 1'b0;
      req_valid = 4'b1000;
      dat[3] = $urandom;
      smp();
      k = 0;
      while (!resp_valid && k < 60) begin
         cycle();
         k++;
      end
      chk("bp_seen", resp_valid, 1);
      for (int i = 0; i < 10; i++) begin
         adv();
         if (i == 0) begin
            req_valid[1] = 1'b1;
            dat[1] = $urandom;
         end
         smp();
         chk("bp_rdy", req_ready, 0);
         chk("bp_valid", resp_valid, 1);
      end
      adv();
      resp_ready = 1'b1;
      smp();
      drain(200);

      // reset during WAIT
      adv();
      req_valid = 4'b0001;
      dat[0] = $urandom;
      smp();
      k = 0;
      while (ngrant == 0 && k < 60) begin
         cycle();
         k++;
      end
      ngrant = 0;
      repeat (11) cycle();
      adv();
      reset = 1'b1;
      #1;
      chk_reset_vals("arst");
      model_reset();
      adv();
      reset = 1'b0;
      req_valid = 4'b0001;
      dat[0] = 32'h0009_0000;
      flush_count(n);
      chk("flush_len3", n, IT + 2);
      drain(200);
      chk("sqrt9", last_rdata, 32'h0003_0000);

      // watchdog: unit never reports done
      force dut.unit_done = 1'b0;
      wd_mode = 1;
      adv();
      req_valid = 4'b0100;
      dat[2] = $urandom;
      smp();
      drain(200);
      wd_mode = 0;
      release dut.unit_done;
      chk("wd_err", last_rerr, 1);
      chk("wd_data", last_rdata, 0);
      chk("wd_idle", busy, 0);

      // random traffic
      rand_mode = 1;
      repeat (600) cycle();
      rand_mode = 0;
      adv();
      resp_ready = 1'b1;
      smp();
      drain(600);

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end
endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin scheduler that shares one iterative `fp_sqrt` unit between `NUM_REQ` requesters. It accepts operands over per-requester valid/ready ports and issues each one to its internal `fp_sqrt` instance with a single-cycle `go` pulse. It then returns the result with the requester's id on a shared response port. It sits between the requesting datapaths and the square-root unit, so the unit is never restarted mid-operation and every `done` is matched to its owner.

## Interface
- `WIDTH`, 32, operand/result width, passed to `fp_sqrt`
- `INT_WIDTH`, 16, integer bits, passed to `fp_sqrt`
- `FRAC_WIDTH`, 16, fraction bits, passed to `fp_sqrt`
- `NUM_REQ`, 4, number of requesters (≥1)
- Derived: `ITER = (WIDTH+FRAC_WIDTH)>>1`; `IDW = max(1, $clog2(NUM_REQ))`
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  operand valid per requester
- `req_data`  in  NUM_REQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
- `req_ready`  out  NUM_REQ  one-hot grant/accept
- `resp_valid`  out  1  result valid
- `resp_ready`  in  1  consumer accepts result
- `resp_data`  out  WIDTH  square root result
- `resp_id`  out  IDW  index of the requester that owns the result
- `resp_err`  out  1  result produced by watchdog timeout, not by the unit
- `busy`  out  1  high in every state except IDLE

## Operation
- Internal `fp_sqrt` instance with `clk` shared. The unit has no reset.
- States are FLUSH, IDLE, ISSUE, WAIT and RESP.
- **FLUSH** (entered on reset):
  - A down-counter loads `ITER+2`.
  - `req_ready=0`, `go=0`, and unit `done` is ignored.
  - Go to IDLE when the counter reaches 0.
- **IDLE**:
  - If any `req_valid` is set, grant the first valid requester searching from `(last_grant+1) mod NUM_REQ` upward with wrap-around.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - On handshake, capture `req_data[g]` into the operand register, record `g` as the id, set `last_grant=g`, and go to ISSUE.
  - `req_ready` is 0 when no request is valid.
- **ISSUE**: drive `go=1` and the operand for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT**:
  - `go=0`, and the watchdog counter increments every cycle.
  - On unit `done=1`, capture unit `out` into `resp_data`, set `resp_err=0`, and go to RESP.
  - If the counter reaches `ITER+4` without `done`, set `resp_data=0` and `resp_err=1`, and go to RESP.
- **RESP**:
  - `resp_valid=1`; `resp_data`, `resp_id` and `resp_err` are held stable.
  - When `resp_ready=1`, go to IDLE.
  - No grant is made while in RESP.
- `go` is never asserted outside ISSUE, so the unit is never re-armed while `done` is pending.
- `last_grant` resets to `NUM_REQ-1`, so requester 0 has top priority after reset.

## Timing
- Reset values:
  - `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_id=0`, `resp_err=0`, `busy=1`
  - state FLUSH, `last_grant=NUM_REQ-1`
- After `reset` deasserts, the first possible `req_ready` comes `ITER+2` cycles later.
- Request handshake in cycle t:
  - ISSUE (`go`) in t+1.
  - Unit `done` is high in t+1+ITER.
  - `resp_valid` rises in t+2+ITER.
- With `resp_ready` held high, the next grant can occur in t+3+ITER. Sustained throughput is one op per `ITER+3` cycles.
- Simultaneous `req_valid`: only one `req_ready` bit is ever high in a cycle.
- A `req_valid` that drops before handshake is not an error. The requester is simply not granted.
- `resp_ready` held low: the response is held indefinitely and all `req_ready` stay 0.
- Reset mid-ISSUE/WAIT/RESP:
  - All outputs return to reset values asynchronously.
  - The in-flight unit operation completes silently during FLUSH.
  - Its `done` is discarded, and no response is issued for it.
- `NUM_REQ=1`: arbitration degenerates and `resp_id` is always 0.

## Test plan
- Single request, WIDTH=32/FRAC=16 (ITER=24): requester 1 sends 0x00040000 (4.0) at cycle t → `resp_valid` at t+26 with `resp_data=0x00020000`, `resp_id=1`, `resp_err=0`.
- All four requesters valid continuously with 0x00010000, 0x00040000, 0x00090000, 0x00020000:
  - Grants occur in order 0,1,2,3,0,…
  - Results are 0x00010000, 0x00020000, 0x00030000 and 0x00016A09, each tagged with the matching id.
  - Grants are spaced 27 cycles apart.
- Round-robin wrap: after a grant to 3, requesters 0 and 2 are valid → 0 is granted first, then 2.
- Backpressure: hold `resp_ready=0` for 10 cycles in RESP → `resp_valid`, `resp_data` and `resp_id` stay stable, and `req_ready` stays 0 throughout.
- Reset in cycle 10 of WAIT, released one cycle later:
  - Outputs are at reset values immediately.
  - `req_ready` stays 0 for 26 cycles, and no stray `resp_valid` appears.
  - A following request of 0x00090000 returns 0x00030000.
- Watchdog: force the unit's `done` low → after `ITER+4`=28 WAIT cycles, a response appears with `resp_err=1` and `resp_data=0`, then the block returns to IDLE.
